// File: rtl/pd_bbox_lw_slave.sv
// pd_bbox_lw_slave: Avalon-MM responder for the double-buffered person bbox table.
// Define PD_BBOX_READBACK_EN to let the HPS read back the table; otherwise the table is write-only from the HPS side.
module pd_bbox_lw_slave #(
  parameter int MAX_BOX = 64,
  parameter int RD_LAT  = 2
) (
  input  logic                       avalon_clk_lw_clk,
  input  logic                       avalon_reset_lw_reset,
  input  logic [11:0]                pd_bbox_h2f_lw_address,
  input  logic                       pd_bbox_h2f_lw_write,
  input  logic                       pd_bbox_h2f_lw_read,
  input  logic [31:0]                pd_bbox_h2f_lw_writedata,
  input  logic [3:0]                 pd_bbox_h2f_lw_byteenable,
  input  logic [3:0]                 pd_bbox_h2f_lw_burstcount,
  input  logic                       pd_bbox_h2f_lw_begintransfer,
  input  logic                       pd_bbox_h2f_lw_beginbursttransfer,
  output logic                       pd_bbox_h2f_lw_waitrequest,
  output logic [31:0]                pd_bbox_h2f_lw_readdata,
  output logic                       pd_bbox_h2f_lw_readdatavalid,
  output logic [7:0]                 pd_bbox_frame_out,
  output logic                       bbox_update,
  output logic [$clog2(MAX_BOX):0]   bbox_count,
  input  logic [$clog2(MAX_BOX)-1:0] bbox_rd_idx,
  output logic [31:0]                bbox_rd_data
);
  localparam int IW = $clog2(MAX_BOX);
  localparam int CW = IW + 1;
  localparam int PL = RD_LAT - 1;
  localparam logic [31:0] ID = 32'h50444242;
  typedef enum logic [1:0] {IDLE, WR_BURST, RD_ISSUE, RD_DRAIN} state_t;
  state_t        r_state;
  logic [9:0]    r_addr;
  logic [3:0]    r_left;
  logic          r_wait, r_bank, r_upd;
  logic [7:0]    r_frame;
  logic [CW-1:0] r_back, r_front;
  logic [31:0]   r_ram [2*MAX_BOX];
  logic [31:0]   r_fab;
  logic [PL-1:0] r_pv;
  logic [31:0]   r_pd [PL];
  logic [3:0]    w_bc;
  logic          w_wr, w_wtbl, w_rtbl, w_commit, w_issue, w_unused;
  logic [9:0]    w_waddr;
  logic [IW-1:0] w_widx;
  logic [31:0]   w_rval, w_tval;

  assign w_unused = ^{pd_bbox_h2f_lw_begintransfer, pd_bbox_h2f_lw_beginbursttransfer, pd_bbox_h2f_lw_address[1:0]};

  always_comb begin
    w_bc = pd_bbox_h2f_lw_burstcount == 4'd0 ? 4'd1 : pd_bbox_h2f_lw_burstcount > 4'd8 ? 4'd8 : pd_bbox_h2f_lw_burstcount;
    w_wr = pd_bbox_h2f_lw_write && (r_state == IDLE || r_state == WR_BURST);
    w_waddr = r_state == IDLE ? pd_bbox_h2f_lw_address[11:2] : r_addr;
    w_wtbl = w_waddr >= 10'd64 && w_waddr < 10'(64 + MAX_BOX);
    w_rtbl = r_addr >= 10'd64 && r_addr < 10'(64 + MAX_BOX);
    w_widx = IW'(w_waddr - 10'd64);
    w_commit = w_wr && w_waddr == 10'd0 && pd_bbox_h2f_lw_byteenable[0] && pd_bbox_h2f_lw_writedata[0];
    w_issue = r_state == RD_ISSUE;
`ifdef PD_BBOX_READBACK_EN
    w_tval = r_ram[{~r_bank, IW'(r_addr - 10'd64)}];
`else
    w_tval = '0;
`endif
    w_rval = r_addr == 10'd0 ? {r_frame, 1'b0, 7'(r_back), 9'd0, 7'(r_front)} :
             r_addr == 10'd1 ? 32'(r_back) :
             r_addr == 10'd2 ? ID :
             w_rtbl ? w_tval : '0;
  end

  always_ff @(posedge avalon_clk_lw_clk) begin
    if (avalon_reset_lw_reset) begin
      r_state <= IDLE;
      r_wait <= 1'b0;
      r_addr <= '0;
      r_left <= '0;
    end else begin
      case (r_state)
        IDLE: if (pd_bbox_h2f_lw_write) begin
          r_addr <= pd_bbox_h2f_lw_address[11:2] + 10'd1;
          r_left <= w_bc - 4'd1;
          r_state <= w_bc > 4'd1 ? WR_BURST : IDLE;
        end else if (pd_bbox_h2f_lw_read) begin
          r_addr <= pd_bbox_h2f_lw_address[11:2];
          r_left <= w_bc;
          r_state <= RD_ISSUE;
          r_wait <= 1'b1;
        end
        WR_BURST: if (pd_bbox_h2f_lw_write) begin
          r_addr <= r_addr + 10'd1;
          r_left <= r_left - 4'd1;
          r_state <= r_left == 4'd1 ? IDLE : WR_BURST;
        end
        RD_ISSUE: begin
          r_addr <= r_addr + 10'd1;
          r_left <= r_left == 4'd1 ? 4'(PL) : r_left - 4'd1;
          r_state <= r_left == 4'd1 ? RD_DRAIN : RD_ISSUE;
        end
        RD_DRAIN: begin
          // r_left counts down to the cycle that presents the final beat
          r_left <= r_left - 4'd1;
          r_state <= r_left == 4'd1 ? IDLE : RD_DRAIN;
          r_wait <= r_left != 4'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge avalon_clk_lw_clk) begin
    if (avalon_reset_lw_reset) begin
      r_bank <= 1'b0;
      r_upd <= 1'b0;
      r_frame <= '0;
      r_back <= '0;
      r_front <= '0;
    end else begin
      r_upd <= w_commit;
      if (w_commit) begin
        r_bank <= ~r_bank;
        r_frame <= r_frame + 8'd1;
        r_front <= r_back;
      end
      if (w_wr && w_waddr == 10'd1 && pd_bbox_h2f_lw_byteenable[0])
        r_back <= {24'd0, pd_bbox_h2f_lw_writedata[7:0]} > MAX_BOX ? CW'(MAX_BOX) : CW'(pd_bbox_h2f_lw_writedata[7:0]);
    end
  end

  always_ff @(posedge avalon_clk_lw_clk) begin
    if (w_wr && w_wtbl)
      for (int b = 0; b < 4; b++)
        if (pd_bbox_h2f_lw_byteenable[b]) r_ram[{~r_bank, w_widx}][8*b +: 8] <= pd_bbox_h2f_lw_writedata[8*b +: 8];
  end

  always_ff @(posedge avalon_clk_lw_clk) begin
    if (avalon_reset_lw_reset) r_fab <= '0;
    else r_fab <= r_ram[{r_bank, bbox_rd_idx}];
  end

  // stage 0 captures the issued beat; further stages stretch latency up to RD_LAT
  always_ff @(posedge avalon_clk_lw_clk) begin
    if (avalon_reset_lw_reset) begin
      r_pv <= '0;
      for (int i = 0; i < PL; i++) r_pd[i] <= '0;
    end else begin
      r_pv[0] <= w_issue;
      r_pd[0] <= w_issue ? w_rval : '0;
      for (int i = 1; i < PL; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  assign pd_bbox_h2f_lw_waitrequest   = r_wait;
  assign pd_bbox_h2f_lw_readdata      = r_pd[PL-1];
  assign pd_bbox_h2f_lw_readdatavalid = r_pv[PL-1];
  assign pd_bbox_frame_out            = r_frame;
  assign bbox_update                  = r_upd;
  assign bbox_count                   = r_front;
  assign bbox_rd_data                 = r_fab;
endmodule

// File: tb/tb_pd_bbox_lw_slave.sv
// tb_pd_bbox_lw_slave: directed vector bench for pd_bbox_lw_slave (either PD_BBOX_READBACK_EN setting).
module tb_pd_bbox_lw_slave;
  localparam int RD_LAT = 2;
  localparam logic [31:0] ID = 32'h50444242;
`ifdef PD_BBOX_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  logic        clk = 1'b0, rst;
  logic [11:0] address;
  logic        write, read, begintransfer, beginbursttransfer;
  logic [31:0] writedata;
  logic [3:0]  byteenable, burstcount;
  logic        waitrequest, readdatavalid, bbox_update;
  logic [31:0] readdata, bbox_rd_data;
  logic [7:0]  frame_out;
  logic [6:0]  bbox_count;
  logic [5:0]  bbox_rd_idx;
  int total = 0, bad = 0, cyc = 0, upd_cnt = 0;
  logic [31:0] wbuf [8];
  logic [31:0] rbuf [8];

  typedef struct {
    bit          wr;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [25];

  pd_bbox_lw_slave #(.MAX_BOX(64), .RD_LAT(RD_LAT)) dut (
    .avalon_clk_lw_clk(clk),
    .avalon_reset_lw_reset(rst),
    .pd_bbox_h2f_lw_address(address),
    .pd_bbox_h2f_lw_write(write),
    .pd_bbox_h2f_lw_read(read),
    .pd_bbox_h2f_lw_writedata(writedata),
    .pd_bbox_h2f_lw_byteenable(byteenable),
    .pd_bbox_h2f_lw_burstcount(burstcount),
    .pd_bbox_h2f_lw_begintransfer(begintransfer),
    .pd_bbox_h2f_lw_beginbursttransfer(beginbursttransfer),
    .pd_bbox_h2f_lw_waitrequest(waitrequest),
    .pd_bbox_h2f_lw_readdata(readdata),
    .pd_bbox_h2f_lw_readdatavalid(readdatavalid),
    .pd_bbox_frame_out(frame_out),
    .bbox_update(bbox_update),
    .bbox_count(bbox_count),
    .bbox_rd_idx(bbox_rd_idx),
    .bbox_rd_data(bbox_rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bbox_update) upd_cnt <= upd_cnt + 1;
  end

  function automatic logic [31:0] tv(input logic [31:0] v);
    return RB ? v : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    for (int b = 0; b < 50 && waitrequest; b++) tick();
    if (waitrequest) check("idle_timeout", {31'd0, waitrequest}, 32'd0);
  endtask

  task automatic do_write(input logic [11:0] a, input int n, input logic [3:0] be, input bit gaps);
    wait_idle();
    address = a; burstcount = 4'(n); byteenable = be;
    for (int k = 0; k < n; k++) begin
      writedata = wbuf[k]; write = 1'b1;
      tick();
      if (gaps && k < n - 1) begin
        write = 1'b0; writedata = 32'hDEADBEEF;
        tick();
      end
    end
    write = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, input logic [3:0] bc, input int n, input string nm);
    int t0, got, wc;
    wait_idle();
    address = a; burstcount = bc; read = 1'b1; t0 = cyc;
    tick();
    read = 1'b0; got = 0; wc = 0;
    for (int b = 0; b < 40 && got < n; b++) begin
      if (waitrequest) wc++;
      if (readdatavalid) begin
        check({nm, "_lat"}, 32'(cyc - t0), 32'(RD_LAT + got));
        check({nm, "_data"}, readdata, rbuf[got]);
        got++;
      end
      if (got < n) tick();
    end
    check({nm, "_beats"}, 32'(got), 32'(n));
    check({nm, "_wait_last"}, {31'd0, waitrequest}, 32'd1);
    tick();
    check({nm, "_wait_drop"}, {31'd0, waitrequest}, 32'd0);
    check({nm, "_rdv_end"}, {31'd0, readdatavalid}, 32'd0);
    check({nm, "_wait_cycles"}, 32'(wc), 32'(n + RD_LAT - 1));
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_waitreq"}, {31'd0, waitrequest}, 32'd0);
    check({nm, "_rdv"}, {31'd0, readdatavalid}, 32'd0);
    check({nm, "_rdata"}, readdata, 32'd0);
    check({nm, "_frame"}, {24'd0, frame_out}, 32'd0);
    check({nm, "_update"}, {31'd0, bbox_update}, 32'd0);
    check({nm, "_count"}, {25'd0, bbox_count}, 32'd0);
    check({nm, "_fab"}, bbox_rd_data, 32'd0);
  endtask

  initial begin
    int got, extra, u0;
    tbl[0]  = '{1'b0, 12'h008, 32'h0, 4'hF, ID};
    tbl[1]  = '{1'b0, 12'h000, 32'h0, 4'hF, 32'h0};
    tbl[2]  = '{1'b0, 12'h004, 32'h0, 4'hF, 32'h0};
    tbl[3]  = '{1'b0, 12'h00C, 32'h0, 4'hF, 32'h0};
    tbl[4]  = '{1'b1, 12'h004, 32'd100, 4'h1, 32'h0};
    tbl[5]  = '{1'b0, 12'h004, 32'h0, 4'hF, 32'd64};
    tbl[6]  = '{1'b1, 12'h004, 32'd5, 4'hE, 32'h0};
    tbl[7]  = '{1'b0, 12'h004, 32'h0, 4'hF, 32'd64};
    tbl[8]  = '{1'b1, 12'h004, 32'h105, 4'hF, 32'h0};
    tbl[9]  = '{1'b0, 12'h004, 32'h0, 4'hF, 32'd5};
    tbl[10] = '{1'b1, 12'h000, 32'h1, 4'hE, 32'h0};
    tbl[11] = '{1'b0, 12'h000, 32'h0, 4'hF, 32'h0005_0000};
    tbl[12] = '{1'b1, 12'h000, 32'h2, 4'h1, 32'h0};
    tbl[13] = '{1'b0, 12'h000, 32'h0, 4'hF, 32'h0005_0000};
    tbl[14] = '{1'b1, 12'h008, 32'h0, 4'hF, 32'h0};
    tbl[15] = '{1'b0, 12'h008, 32'h0, 4'hF, ID};
    tbl[16] = '{1'b1, 12'h200, 32'hFFFFFFFF, 4'hF, 32'h0};
    tbl[17] = '{1'b0, 12'h200, 32'h0, 4'hF, 32'h0};
    tbl[18] = '{1'b1, 12'h104, 32'h0, 4'hF, 32'h0};
    tbl[19] = '{1'b1, 12'h104, 32'hAABBCCDD, 4'h2, 32'h0};
    tbl[20] = '{1'b0, 12'h104, 32'h0, 4'hF, tv(32'h0000CC00)};
    tbl[21] = '{1'b1, 12'h1FC, 32'h12345678, 4'hF, 32'h0};
    tbl[22] = '{1'b0, 12'h1FC, 32'h0, 4'hF, tv(32'h12345678)};
    tbl[23] = '{1'b1, 12'h0FC, 32'h1, 4'hF, 32'h0};
    tbl[24] = '{1'b0, 12'h0FC, 32'h0, 4'hF, 32'h0};
    rst = 1'b1; address = '0; write = 1'b0; read = 1'b0; writedata = '0; byteenable = '0; burstcount = '0;
    begintransfer = 1'b0; beginbursttransfer = 1'b0; bbox_rd_idx = '0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();
    for (int i = 0; i < 25; i++) begin
      if (tbl[i].wr) begin
        wbuf[0] = tbl[i].d;
        do_write(tbl[i].a, 1, tbl[i].be, 1'b0);
      end else begin
        rbuf[0] = tbl[i].exp;
        do_read(tbl[i].a, 4'd1, 1, $sformatf("vec%0d", i));
      end
    end
    check("no_commit_yet", 32'(upd_cnt), 32'd0);
    // 8-beat gapped burst into the back bank, then publish it
    for (int k = 0; k < 8; k++) wbuf[k] = 32'h11 * (k + 1);
    do_write(12'h100, 8, 4'hF, 1'b1);
    wbuf[0] = 32'd8;
    do_write(12'h004, 1, 4'h1, 1'b0);
    wbuf[0] = 32'd1;
    do_write(12'h000, 1, 4'h1, 1'b0);
    check("c1_update", {31'd0, bbox_update}, 32'd1);
    check("c1_frame", {24'd0, frame_out}, 32'd1);
    check("c1_count", {25'd0, bbox_count}, 32'd8);
    bbox_rd_idx = 6'd7;
    tick();
    check("c1_update_off", {31'd0, bbox_update}, 32'd0);
    check("c1_fab7", bbox_rd_data, 32'h88);
    wbuf[0] = 32'h77777777;
    do_write(12'h11C, 1, 4'hF, 1'b0);
    wbuf[0] = 32'd1;
    do_write(12'h000, 1, 4'h1, 1'b0);
    check("c2_fab_old_bank", bbox_rd_data, 32'h88);
    tick();
    check("c2_fab_new_bank", bbox_rd_data, 32'h77777777);
    check("c2_frame", {24'd0, frame_out}, 32'd2);
    u0 = upd_cnt;
    wbuf[0] = 32'd1; wbuf[1] = 32'd3; wbuf[2] = 32'hDEAD;
    do_write(12'h000, 3, 4'hF, 1'b0);
    tick();
    check("c3_pulses", 32'(upd_cnt - u0), 32'd1);
    check("c3_count", {25'd0, bbox_count}, 32'd8);
    rbuf[0] = 32'h03030008;
    do_read(12'h000, 4'd1, 1, "c3_ctrl");
    rbuf[0] = 32'h03030008; rbuf[1] = 32'd3; rbuf[2] = ID;
    for (int k = 3; k < 8; k++) rbuf[k] = 32'd0;
    do_read(12'h000, 4'd15, 8, "clamp15");
    rbuf[0] = ID;
    do_read(12'h008, 4'd0, 1, "bc0");
    wbuf[0] = 32'hA0; wbuf[1] = 32'hB1; wbuf[2] = 32'hC2; wbuf[3] = 32'hD3;
    do_write(12'h100, 4, 4'hF, 1'b0);
    for (int k = 0; k < 4; k++) rbuf[k] = tv(wbuf[k]);
    do_read(12'h100, 4'd4, 4, "rd_burst4");
    u0 = upd_cnt;
    for (int i = 0; i < 253; i++) begin
      wbuf[0] = 32'd1;
      do_write(12'h000, 1, 4'h1, 1'b0);
    end
    tick();
    tick();
    check("wrap_frame", {24'd0, frame_out}, 32'd0);
    check("wrap_pulses", 32'(upd_cnt - u0), 32'd253);
    check("wrap_count", {25'd0, bbox_count}, 32'd3);
    rbuf[0] = 32'h00030003;
    do_read(12'h000, 4'd1, 1, "wrap_ctrl");
    // reset while beat 2 of a 6-beat read is on the bus
    wait_idle();
    address = 12'h008; burstcount = 4'd6; read = 1'b1;
    tick();
    read = 1'b0; got = 0;
    for (int b = 0; b < 20 && got < 3; b++) begin
      if (readdatavalid) got++;
      if (got < 3) tick();
    end
    check("rst_pre_beats", 32'(got), 32'd3);
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0; extra = 0;
    repeat (10) begin
      tick();
      if (readdatavalid) extra++;
    end
    check("rst_extra_rdv", 32'(extra), 32'd0);
    rbuf[0] = ID;
    do_read(12'h008, 4'd1, 1, "id_after_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
